// File: rtl/led_bank_scheduler.sv
// led_bank_scheduler: round-robin time-multiplexer of a 16-LED bank among
// four pattern requesters, each holding the bank for a fixed tick-based slot.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   req[3:0]   in   level-sensitive bank requests
//   done[3:0]  in   early-release pulses (only the owner's bit matters)
//   data[63:0] in   patterns, requester i on bits [16i+15:16i]
//   gnt[3:0]   out  registered one-hot grant, zero when the bank is free
//   led[15:0]  out  registered LED drive, one cycle behind gnt
//   busy       out  high while granting or blanking between owners
//   slot_tick  out  one-cycle pulse on each prescaler tick during a grant
//
// Parameters: TICK_DIV (clk cycles per tick, >= 2),
//             HOLD_TICKS (ticks per slot, >= 1).
// Macro LED_GAP_EN: when defined, every handover passes through a one-tick
// blank (GAP) with led = 0; when undefined, handover is back-to-back.
module led_bank_scheduler #(
  parameter int unsigned TICK_DIV   = 12000000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic [63:0] data,
  output logic [3:0]  gnt,
  output logic [15:0] led,
  output logic        busy,
  output logic        slot_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS) + 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

`ifdef LED_GAP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [15:0]   led_q, led_d;

  logic          tick;
  logic          owner_req;
  logic          owner_done;
  logic          hold_end;
  logic          release_c;

  logic [3:0]    arb_mask;
  logic [3:0]    arb_req;
  logic          arb_hit;
  logic [1:0]    arb_idx;
  logic [1:0]    cand;

  // last_q doubles as the current owner while granted
  assign tick       = (presc_q == PRE_LAST);
  assign owner_req  = req[last_q];
  assign owner_done = done[last_q];
  assign hold_end   = tick && (hold_q == HOLD_LAST);
  assign release_c  = !owner_req || owner_done || hold_end;

  // An owner leaving via done must not win the arbitration it triggers
  assign arb_mask = (state_q == S_GRANT && owner_done)
                  ? (4'b0001 << last_q) : 4'b0000;
  assign arb_req  = req & ~arb_mask;

  // Round-robin search from last_q+1; the last owner is tried last
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = last_q;
    cand    = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!arb_hit && arb_req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_d = S_GRANT;
          last_d  = arb_idx;
          presc_d = '0;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          hold_d = hold_q + 1'b1;
        end
        if (release_c) begin
          presc_d = '0;
          hold_d  = '0;
`ifdef LED_GAP_EN
          state_d = S_GAP;
`else
          if (arb_hit) begin
            state_d = S_GRANT;
            last_d  = arb_idx;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end
      end
`ifdef LED_GAP_EN
      S_GAP: begin
        presc_d = presc_q + 1'b1;
        if (tick) begin
          presc_d = '0;
          hold_d  = '0;
          if (arb_hit) begin
            state_d = S_GRANT;
            last_d  = arb_idx;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    gnt_d = 4'b0000;
    if (state_d == S_GRANT) begin
      gnt_d = 4'b0001 << last_d;
    end
  end

  always_comb begin
    led_d = 16'h0000;
    if (gnt_q != 4'b0000) begin
      led_d = data[{last_q, 4'b0000} +: 16];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      presc_q <= '0;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      led_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
    end
  end

  assign gnt       = gnt_q;
  assign led       = led_q;
  assign busy      = (state_q != S_IDLE);
  assign slot_tick = (state_q == S_GRANT) && tick;

endmodule

// File: tb/tb_led_bank_scheduler.sv
// tb_led_bank_scheduler: directed bench for led_bank_scheduler
// with TICK_DIV=4, HOLD_TICKS=3; expectations follow LED_GAP_EN.
module tb_led_bank_scheduler;

  localparam int TD   = 4;
  localparam int HT   = 3;
  localparam int SLOT = HT * TD;
`ifdef LED_GAP_EN
  localparam int GAPC = TD;
`else
  localparam int GAPC = 0;
`endif
  localparam int PER  = SLOT + GAPC;

  localparam logic [15:0] D0 = 16'hA5A5;
  localparam logic [15:0] D1 = 16'h1234;
  localparam logic [15:0] D2 = 16'h00FF;
  localparam logic [15:0] D3 = 16'h8001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  done = 4'b0000;
  logic [63:0] data;
  logic [3:0]  gnt;
  logic [15:0] led;
  logic        busy;
  logic        slot_tick;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int          p;
  int          k;
  logic [3:0]  eg;
  logic [15:0] eled;
  logic [15:0] eled_nx;

  assign data = {D3, D2, D1, D0};

  led_bank_scheduler #(
    .TICK_DIV  (TD),
    .HOLD_TICKS(HT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .data     (data),
    .gnt      (gnt),
    .led      (led),
    .busy     (busy),
    .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] dsel(input int i);
    case (i)
      0:       return D0;
      1:       return D1;
      2:       return D2;
      default: return D3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) step();
  endtask

  // Async reset mid-cycle, outputs must clear before the next edge;
  // released just after an edge, which becomes cycle 0
  task automatic rst_apply();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_led", led, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_tick", 16'(slot_tick), 16'h0);
    req  = 4'b0000;
    done = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #2;
    reset = 1'b1;
    rst_apply();

    // Single requester
    req = 4'b0001;
    eled = 16'h0;
    for (int c = 1; c <= 2 * PER + 4; c++) begin
      step();
      p  = (c - 1) % PER;
      eg = (p < SLOT) ? 4'b0001 : 4'b0000;
      chk("a_gnt", 16'(gnt), 16'(eg));
      chk("a_led", led, eled);
      chk("a_tick", 16'(slot_tick),
          16'((p < SLOT) && ((p % TD) == TD - 1)));
      eled = (p < SLOT) ? D0 : 16'h0;
    end

    // Round robin with all four requesting
    rst_apply();
    req = 4'b1111;
    eled = 16'h0;
    for (int c = 1; c <= 4 * PER + 2; c++) begin
      step();
      k  = (c - 1) / PER;
      p  = (c - 1) % PER;
      eg = (p < SLOT) ? (4'b0001 << (k % 4)) : 4'b0000;
      eled_nx = (p < SLOT) ? dsel(k % 4) : 16'h0;
      chk("rr_gnt", 16'(gnt), 16'(eg));
      chk("rr_led", led, eled);
      eled = eled_nx;
    end

    // Mid-slot reset with everyone requesting, then first grant is 0
    rst_apply();
    req = 4'b1111;
    step();
    chk("rst_first", 16'(gnt), 16'h0001);

    // Early release of owner 1 via done, next goes to 2
    rst_apply();
    req = 4'b0110;
    go_to(5);
    chk("er_own", 16'(gnt), 16'h0002);
    done = 4'b0010;
    step();
    done = 4'b0000;
`ifdef LED_GAP_EN
    chk("er_drop", 16'(gnt), 16'h0000);
    chk("er_led", led, D1);
    chk("er_busy", 16'(busy), 16'h1);
    go_to(10);
    chk("er_next", 16'(gnt), 16'h0004);
    step();
    chk("er_led2", led, D2);
`else
    chk("er_next", 16'(gnt), 16'h0004);
    chk("er_led", led, D1);
    step();
    chk("er_led2", led, D2);
`endif

    // done from a lone requester masks it out of the handover arbitration
    rst_apply();
    req = 4'b0010;
    go_to(3);
    done = 4'b0010;
    step();
    done = 4'b0000;
    chk("dm_drop", 16'(gnt), 16'h0000);
`ifdef LED_GAP_EN
    chk("dm_busy", 16'(busy), 16'h1);
    go_to(7);
    chk("dm_gap", 16'(gnt), 16'h0000);
    step();
    chk("dm_regnt", 16'(gnt), 16'h0002);
`else
    chk("dm_busy", 16'(busy), 16'h0);
    step();
    chk("dm_regnt", 16'(gnt), 16'h0002);
`endif

    // Two requesters handing over at slot end
    rst_apply();
    req = 4'b0011;
    go_to(12);
    chk("ho_last", 16'(gnt), 16'h0001);
    step();
`ifdef LED_GAP_EN
    chk("ho_gap", 16'(gnt), 16'h0000);
    chk("ho_led", led, D0);
    step();
    chk("ho_blank", led, 16'h0000);
    go_to(17);
    chk("ho_next", 16'(gnt), 16'h0002);
`else
    chk("ho_next", 16'(gnt), 16'h0002);
    chk("ho_led", led, D0);
    step();
    chk("ho_led2", led, D1);
`endif

    // Owner drops req exactly on its final tick
    rst_apply();
    req = 4'b1111;
    step();
    chk("co_first", 16'(gnt), 16'h0001);
    go_to(12);
    chk("co_tick", 16'(slot_tick), 16'h1);
    req = 4'b1110;
    step();
`ifdef LED_GAP_EN
    chk("co_gap", 16'(gnt), 16'h0000);
    go_to(16);
    chk("co_gap_end", 16'(gnt), 16'h0000);
    step();
    chk("co_next", 16'(gnt), 16'h0002);
    go_to(28);
    chk("co_hold", 16'(gnt), 16'h0002);
    go_to(33);
    chk("co_after", 16'(gnt), 16'h0004);
`else
    chk("co_next", 16'(gnt), 16'h0002);
    go_to(24);
    chk("co_hold", 16'(gnt), 16'h0002);
    step();
    chk("co_after", 16'(gnt), 16'h0004);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
